text_console_writer: RTL and testbench



---
 rtl/text_console_writer_if.sv | 18 +
 rtl/text_console_writer.sv | 120 ++++++++++++
 tb/tb_text_console_writer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/text_console_writer_if.sv
// text_console_writer_if: character input handshake and text RAM write port.
// Signals: in_valid/in_ready/in_char/in_attr (character stream),
// ram_en/ram_we/ram_addr/ram_din (write port). Modports: master = host/RAM side,
// slave = the console writer engine.
interface text_console_writer_if #(parameter int ADDR_W = 12);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_char;
    logic [7:0]        in_attr;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_din;
    modport master (output in_valid, in_char, in_attr,
                    input  in_ready, ram_en, ram_we, ram_addr, ram_din);
    modport slave  (input  in_valid, in_char, in_attr,
                    output in_ready, ram_en, ram_we, ram_addr, ram_din);
endinterface

// File: rtl/text_console_writer.sv
// text_console_writer: turns a character stream into {attr, char} cell writes with cursor, control codes and clear sweeps.
// Ports: clk, rst (async, active-high); bus (slave modport: character handshake in,
// RAM write port out); cursor_col/cursor_row (current cursor); busy (state != IDLE).
module text_console_writer #(
    parameter int         COLS   = 80,
    parameter int         ROWS   = 30,
    parameter int         ADDR_W = 12,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst,
    text_console_writer_if.slave  bus,
    output logic [6:0]            cursor_col,
    output logic [4:0]            cursor_row,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_ALL} state_t;
    localparam logic [6:0]        COL_MAX = 7'(COLS - 1);
    localparam logic [4:0]        ROW_MAX = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(COLS * ROWS - 1);
    state_t            state, state_n;
    logic [6:0]        col_n;
    logic [4:0]        row_n, row_inc;
    logic [7:0]        attr, attr_n;
    logic              en_n;
    logic [ADDR_W-1:0] addr_n;
    logic [15:0]       din_n;
    function automatic logic [ADDR_W-1:0] base(input logic [4:0] r);
        return ADDR_W'(r) * ADDR_W'(COLS);
    endfunction
    assign row_inc = (cursor_row == ROW_MAX) ? 5'd0 : cursor_row + 5'd1;
    always_comb begin
        state_n = state;
        col_n   = cursor_col;
        row_n   = cursor_row;
        attr_n  = attr;
        en_n    = 1'b0;
        addr_n  = bus.ram_addr;
        din_n   = bus.ram_din;
        case (state)
            IDLE: if (bus.in_valid) begin
                attr_n = bus.in_attr;
                if (bus.in_char >= 8'h20 && bus.in_char <= 8'h7E) begin
                    state_n = WRITE;
                    en_n    = 1'b1;
                    addr_n  = base(cursor_row) + ADDR_W'(cursor_col);
                    din_n   = {bus.in_attr, bus.in_char};
                end else if (bus.in_char == 8'h0D) begin
                    col_n = 7'd0;
                end else if (bus.in_char == 8'h0A) begin
                    col_n   = 7'd0;
                    row_n   = row_inc;
                    state_n = CLR_LINE;
                    en_n    = 1'b1;
                    addr_n  = base(row_inc);
                    din_n   = {bus.in_attr, BLANK};
                end else if (bus.in_char == 8'h08) begin
                    col_n = (cursor_col != 7'd0) ? cursor_col - 7'd1 : cursor_col;
                end else if (bus.in_char == 8'h0C) begin
                    col_n   = 7'd0;
                    row_n   = 5'd0;
                    state_n = CLR_ALL;
                    en_n    = 1'b1;
                    addr_n  = '0;
                    din_n   = {bus.in_attr, BLANK};
                end
            end
            WRITE: if (cursor_col == COL_MAX) begin
                col_n   = 7'd0;
                row_n   = row_inc;
                state_n = CLR_LINE;
                en_n    = 1'b1;
                addr_n  = base(row_inc);
                din_n   = {attr, BLANK};
            end else begin
                col_n   = cursor_col + 7'd1;
                state_n = IDLE;
            end
            // the cursor row already points at the line being cleared
            CLR_LINE: if (bus.ram_addr == base(cursor_row) + ADDR_W'(COLS - 1)) begin
                state_n = IDLE;
            end else begin
                en_n   = 1'b1;
                addr_n = bus.ram_addr + 1'b1;
            end
            CLR_ALL: if (bus.ram_addr == LAST) begin
                state_n = IDLE;
            end else begin
                en_n   = 1'b1;
                addr_n = bus.ram_addr + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            attr         <= '0;
            cursor_col   <= '0;
            cursor_row   <= '0;
            busy         <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.ram_en   <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_din  <= '0;
        end else begin
            state        <= state_n;
            attr         <= attr_n;
            cursor_col   <= col_n;
            cursor_row   <= row_n;
            busy         <= state_n != IDLE;
            bus.in_ready <= state_n == IDLE;
            bus.ram_en   <= en_n;
            bus.ram_we   <= en_n;
            bus.ram_addr <= addr_n;
            bus.ram_din  <= din_n;
        end
    end
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: directed bench with a write scoreboard for text_console_writer.
module tb_text_console_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic busy;
    int n_checks = 0;
    int n_fail = 0;
    int n_writes = 0;
    int mrow = 0;
    int mcol = 0;
    logic [27:0] exp_q[$];
    text_console_writer_if #(.ADDR_W(12)) bus ();
    text_console_writer dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    function automatic void push_line(input int r, input logic [7:0] a);
        for (int i = 0; i < 80; i++) exp_q.push_back({12'(r * 80 + i), a, 8'h20});
    endfunction
    // reference cursor model; pushes the writes each code should cause
    task automatic send(input logic [7:0] c, input logic [7:0] a);
        int k;
        k = 0;
        while (!bus.in_ready && k < 5000) begin
            @(posedge clk); #1; k++;
        end
        chk("ready_before_send", {31'd0, bus.in_ready}, 32'd1);
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_q.push_back({12'(mrow * 80 + mcol), a, c});
            if (mcol == 79) begin
                mcol = 0;
                mrow = (mrow + 1) % 30;
                push_line(mrow, a);
            end else mcol++;
        end else if (c == 8'h0D) mcol = 0;
        else if (c == 8'h0A) begin
            mcol = 0;
            mrow = (mrow + 1) % 30;
            push_line(mrow, a);
        end else if (c == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (c == 8'h0C) begin
            mcol = 0;
            mrow = 0;
            for (int i = 0; i < 2400; i++) exp_q.push_back({12'(i), a, 8'h20});
        end
        bus.in_valid = 1'b1;
        bus.in_char = c;
        bus.in_attr = a;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask
    task automatic run(output int nbusy, output int nwait);
        nbusy = 0;
        nwait = 0;
        for (int k = 0; k < 5000 && (busy || !bus.in_ready); k++) begin
            nbusy += int'(busy);
            nwait += int'(!bus.in_ready);
            @(posedge clk); #1;
        end
    endtask
    task automatic chk_cursor(input string tag);
        chk({tag, "_col"}, 32'(cursor_col), 32'(mcol));
        chk({tag, "_row"}, 32'(cursor_row), 32'(mrow));
    endtask
    always @(negedge clk) begin
        if (bus.ram_en) begin
            logic [27:0] e;
            n_writes++;
            chk("ram_we", {31'd0, bus.ram_we}, 32'd1);
            if (exp_q.size() == 0) chk("unexpected_write", {4'd0, bus.ram_addr, bus.ram_din}, 32'hFFFFFFFF);
            else begin
                e = exp_q.pop_front();
                chk("ram_addr", 32'(bus.ram_addr), 32'(e[27:16]));
                chk("ram_din", 32'(bus.ram_din), 32'(e[15:0]));
            end
        end
    end
    initial begin
        int nb, nw, w0;
        bus.in_valid = 1'b0;
        bus.in_char = 8'h00;
        bus.in_attr = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_en", {31'd0, bus.ram_en}, 32'd0);
        chk("rst_we", {31'd0, bus.ram_we}, 32'd0);
        chk("rst_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_din", 32'(bus.ram_din), 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_cursor("rst");
        send(8'h41, 8'h1F);
        chk("A_en_n1", {31'd0, bus.ram_en}, 32'd1);
        chk("A_addr_n1", 32'(bus.ram_addr), 32'd0);
        chk("A_din_n1", 32'(bus.ram_din), 32'h1F41);
        chk("A_ready_n1", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("A_en_n2", {31'd0, bus.ram_en}, 32'd0);
        chk("A_ready_n2", {31'd0, bus.in_ready}, 32'd1);
        chk_cursor("A");
        chk("A_col_const", 32'(cursor_col), 32'd1);
        send(8'h0D, 8'h07);
        send(8'h0A, 8'h07);
        run(nb, nw);
        send(8'h0A, 8'h07);
        run(nb, nw);
        for (int i = 0; i < 79; i++) begin
            send(8'h2E, 8'h07);
            run(nb, nw);
        end
        chk("pre_wrap_col", 32'(cursor_col), 32'd79);
        chk("pre_wrap_row", 32'(cursor_row), 32'd2);
        send(8'h5A, 8'h07);
        chk("Z_addr", 32'(bus.ram_addr), 32'd239);
        chk("Z_din", 32'(bus.ram_din), 32'h075A);
        run(nb, nw);
        chk("wrap_ready_low", 32'(nw), 32'd81);
        chk_cursor("wrap");
        chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 26; i++) begin
            send(8'h0A, 8'h07);
            run(nb, nw);
        end
        for (int i = 0; i < 5; i++) begin
            send(8'h2E, 8'h07);
            run(nb, nw);
        end
        chk("pre_lf_row", 32'(cursor_row), 32'd29);
        chk("pre_lf_col", 32'(cursor_col), 32'd5);
        send(8'h0A, 8'h07);
        chk_cursor("lf_n1");
        run(nb, nw);
        chk("lf_busy_cycles", 32'(nb), 32'd80);
        chk("lf_q_empty", 32'(exp_q.size()), 32'd0);
        w0 = n_writes;
        send(8'h08, 8'h07);
        chk_cursor("bs0");
        send(8'h01, 8'h07);
        chk("other_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk_cursor("other");
        chk("no_write", 32'(n_writes), 32'(w0));
        for (int i = 0; i < 10; i++) begin
            send(8'h61, 8'h07);
            run(nb, nw);
        end
        send(8'h08, 8'h07);
        chk("bs10_col", 32'(cursor_col), 32'd9);
        for (int i = 0; i < 31; i++) begin
            send(8'h62, 8'h07);
            run(nb, nw);
        end
        chk("pre_cr_col", 32'(cursor_col), 32'd40);
        send(8'h0D, 8'h07);
        chk("cr_col", 32'(cursor_col), 32'd0);
        chk_cursor("cr");
        send(8'h0C, 8'h70);
        chk_cursor("ff_n1");
        run(nb, nw);
        chk("ff_ready_low", 32'(nw), 32'd2400);
        chk("ff_q_empty", 32'(exp_q.size()), 32'd0);
        send(8'h41, 8'h07);
        run(nb, nw);
        send(8'h0C, 8'h70);
        w0 = n_writes;
        repeat (999) @(posedge clk);
        #1;
        chk("ff_1000th_en", {31'd0, bus.ram_en}, 32'd1);
        chk("ff_1000th_addr", 32'(bus.ram_addr), 32'd999);
        rst = 1'b1;
        #1;
        chk("rst_mid_en", {31'd0, bus.ram_en}, 32'd0);
        chk("rst_mid_col", 32'(cursor_col), 32'd0);
        chk("rst_mid_row", 32'(cursor_row), 32'd0);
        chk("rst_mid_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        #1;
        chk("rst_mid_writes", 32'(n_writes - w0), 32'd999);
        exp_q.delete();
        mrow = 0;
        mcol = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'h42, 8'h07);
        run(nb, nw);
        chk("B_q_empty", 32'(exp_q.size()), 32'd0);
        chk_cursor("B");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
